// File: rtl/matrix_input_loader.sv
// matrix_input_loader
//   Loads matrix A (M x K) followed by matrix B (K x N) from one AXI-Stream
//   input into two internal memories, row-major, and holds them for the
//   compute block until compute_finished. A previously loaded A may be reused
//   (new_A=0 on the first beat), K is range-checked at runtime, and TVALID gaps
//   are tolerated in every state.
//
//   Optional feature: define MATRIX_LOADER_TLAST_CHK_EN to add the AXIS_TLAST
//   input and flag/abort transfers whose TLAST placement is wrong.
//
// Ports
//   clk, reset        clock (rising edge) / asynchronous active-high reset
//   AXIS_TDATA        signed stream element
//   AXIS_TVALID       element valid
//   AXIS_TUSER        [0]=new_A, [K_BITS:1]=K; only looked at on the first beat
//   AXIS_TREADY       loader can accept a beat
//   AXIS_TLAST        (optional) end-of-transfer marker
//   matrices_loaded   A and B complete; contents stable
//   compute_finished  single-cycle release pulse from compute
//   K                 shared dimension of the stored matrices
//   A_read_addr       A read address (row*K+col); A_data valid one cycle later
//   B_read_addr       B read address (row*N+col); B_data valid one cycle later
//   load_error        sticky error flag, cleared only by reset
module matrix_input_loader #(
  parameter int INW  = 12,
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8,
  localparam int K_BITS      = $clog2(MAXK + 1),
  localparam int A_ADDR_BITS = $clog2(M * MAXK),
  localparam int B_ADDR_BITS = $clog2(MAXK * N)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [INW-1:0]         AXIS_TDATA,
  input  logic                          AXIS_TVALID,
  input  logic        [K_BITS:0]        AXIS_TUSER,
`ifdef MATRIX_LOADER_TLAST_CHK_EN
  input  logic                          AXIS_TLAST,
`endif
  output logic                          AXIS_TREADY,
  output logic                          matrices_loaded,
  input  logic                          compute_finished,
  output logic        [K_BITS-1:0]      K,
  input  logic        [A_ADDR_BITS-1:0] A_read_addr,
  output logic signed [INW-1:0]         A_data,
  input  logic        [B_ADDR_BITS-1:0] B_read_addr,
  output logic signed [INW-1:0]         B_data,
  output logic                          load_error
);

  localparam int AW1 = A_ADDR_BITS + 1;
  localparam int BW1 = B_ADDR_BITS + 1;
  localparam int CW  = ((A_ADDR_BITS > B_ADDR_BITS) ? A_ADDR_BITS : B_ADDR_BITS) + 1;

`ifdef MATRIX_LOADER_TLAST_CHK_EN
  localparam bit TLAST_CHK = 1'b1;
`else
  localparam bit TLAST_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOADED
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [K_BITS-1:0] k_q, k_d;
  logic              a_valid_q, a_valid_d;
  logic              loaded_q, loaded_d;
  logic              err_q, err_d;
  logic signed [INW-1:0] a_data_q, a_data_d;
  logic signed [INW-1:0] b_data_q, b_data_d;

  logic signed [INW-1:0] a_mem [2**A_ADDR_BITS];
  logic signed [INW-1:0] b_mem [2**B_ADDR_BITS];

  logic                   a_we, b_we;
  logic [A_ADDR_BITS-1:0] a_waddr;
  logic [B_ADDR_BITS-1:0] b_waddr;

  logic              beat;
  logic              tlast;
  logic              tuser_new_a;
  logic [K_BITS-1:0] tuser_k;
  logic              tuser_k_ok;
  logic [AW1-1:0]    a_total_cur, a_total_new;
  logic [BW1-1:0]    b_total_cur;
  logic              a_last, b_last;
  logic              abort;

`ifdef MATRIX_LOADER_TLAST_CHK_EN
  assign tlast = AXIS_TLAST;
`else
  assign tlast = 1'b0;
`endif

  assign AXIS_TREADY     = (state_q != LOADED) & ~reset;
  assign beat            = AXIS_TVALID & AXIS_TREADY;
  assign matrices_loaded = loaded_q;
  assign K               = k_q;
  assign load_error      = err_q;
  assign A_data          = a_data_q;
  assign B_data          = b_data_q;

  assign tuser_new_a = AXIS_TUSER[0];
  assign tuser_k     = AXIS_TUSER[K_BITS:1];
  assign tuser_k_ok  = (tuser_k != '0) && (tuser_k <= K_BITS'(MAXK));

  // Element counts are one bit wider than the address so K=MAXK cannot wrap.
  assign a_total_cur = AW1'(M) * AW1'(k_q);
  assign a_total_new = AW1'(M) * AW1'(tuser_k);
  assign b_total_cur = BW1'(N) * BW1'(k_q);
  assign a_last      = (cnt_q == (CW'(a_total_cur) - CW'(1)));
  assign b_last      = (cnt_q == (CW'(b_total_cur) - CW'(1)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    a_valid_d = a_valid_q;
    loaded_d  = loaded_q;
    err_d     = err_q;
    a_we      = 1'b0;
    b_we      = 1'b0;
    a_waddr   = cnt_q[A_ADDR_BITS-1:0];
    b_waddr   = cnt_q[B_ADDR_BITS-1:0];
    abort     = 1'b0;
    a_data_d  = a_mem[A_read_addr];
    b_data_d  = b_mem[B_read_addr];

    case (state_q)
      IDLE: begin
        if (beat) begin
          if (tuser_new_a && tuser_k_ok) begin
            // The first A beat can never be the final B beat.
            if (tlast) begin
              abort = 1'b1;
            end else begin
              k_d       = tuser_k;
              a_valid_d = 1'b0;
              a_we      = 1'b1;
              a_waddr   = '0;
              if (a_total_new == AW1'(1)) begin
                a_valid_d = 1'b1;
                cnt_d     = '0;
                state_d   = LOAD_B;
              end else begin
                cnt_d   = CW'(1);
                state_d = LOAD_A;
              end
            end
          end else if (!tuser_new_a && a_valid_q) begin
            if (tlast && (b_total_cur != BW1'(1))) begin
              abort = 1'b1;
            end else begin
              b_we    = 1'b1;
              b_waddr = '0;
              if (b_total_cur == BW1'(1)) begin
                cnt_d    = '0;
                loaded_d = 1'b1;
                state_d  = LOADED;
                if (TLAST_CHK && !tlast) err_d = 1'b1;
              end else begin
                cnt_d   = CW'(1);
                state_d = LOAD_B;
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD_A: begin
        if (beat) begin
          if (tlast) begin
            abort = 1'b1;
          end else begin
            a_we = 1'b1;
            if (a_last) begin
              cnt_d     = '0;
              a_valid_d = 1'b1;
              state_d   = LOAD_B;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end

      LOAD_B: begin
        if (beat) begin
          if (tlast && !b_last) begin
            abort = 1'b1;
          end else begin
            b_we = 1'b1;
            if (b_last) begin
              cnt_d    = '0;
              loaded_d = 1'b1;
              state_d  = LOADED;
              if (TLAST_CHK && !tlast) err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end

      LOADED: begin
        if (compute_finished) begin
          loaded_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Early TLAST drops the beat and discards the whole transfer.
    if (abort) begin
      a_we      = 1'b0;
      b_we      = 1'b0;
      err_d     = 1'b1;
      a_valid_d = 1'b0;
      cnt_d     = '0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      a_valid_q <= 1'b0;
      loaded_q  <= 1'b0;
      err_q     <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      a_valid_q <= a_valid_d;
      loaded_q  <= loaded_d;
      err_q     <= err_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
    end
  end

  // Memory arrays are not reset; contents survive reset and aborts.
  always_ff @(posedge clk) begin
    if (a_we) a_mem[a_waddr] <= AXIS_TDATA;
    if (b_we) b_mem[b_waddr] <= AXIS_TDATA;
  end

endmodule

// File: tb/tb_matrix_input_loader.sv
module tb_matrix_input_loader;
  localparam int INW = 12;
  localparam int M   = 7;
  localparam int N   = 9;
  localparam int KB  = 4;
  localparam int AAB = 6;
  localparam int BAB = 7;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [INW-1:0] AXIS_TDATA = '0;
  logic           AXIS_TVALID = 1'b0;
  logic [KB:0]    AXIS_TUSER = '0;
`ifdef MATRIX_LOADER_TLAST_CHK_EN
  logic           AXIS_TLAST = 1'b0;
`endif
  logic           AXIS_TREADY;
  logic           matrices_loaded;
  logic           compute_finished = 1'b0;
  logic [KB-1:0]  K;
  logic [AAB-1:0] A_read_addr = '0;
  logic [INW-1:0] A_data;
  logic [BAB-1:0] B_read_addr = '0;
  logic [INW-1:0] B_data;
  logic           load_error;

  matrix_input_loader #(.INW(INW), .M(M), .N(N), .MAXK(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .AXIS_TDATA       (AXIS_TDATA),
    .AXIS_TVALID      (AXIS_TVALID),
    .AXIS_TUSER       (AXIS_TUSER),
`ifdef MATRIX_LOADER_TLAST_CHK_EN
    .AXIS_TLAST       (AXIS_TLAST),
`endif
    .AXIS_TREADY      (AXIS_TREADY),
    .matrices_loaded  (matrices_loaded),
    .compute_finished (compute_finished),
    .K                (K),
    .A_read_addr      (A_read_addr),
    .A_data           (A_data),
    .B_read_addr      (B_read_addr),
    .B_data           (B_data),
    .load_error       (load_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: plain arrays of what each memory location should hold.
  logic [INW-1:0] ref_a [56];
  logic [INW-1:0] ref_b [72];
  bit             def_a [56];
  bit             def_b [72];

  typedef struct {
    bit       new_a;
    logic [3:0] kf;
    bit       exp_accept;
    int       exp_k;
    bit       exp_err;
    bit       gaps;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Entered and left at a falling edge; the beat happens on the rising edge between.
  task automatic send_beat(input logic [INW-1:0] d, input logic [KB:0] tu, input bit gaps, input bit last);
    int g;
    if (gaps) begin
      g = $urandom_range(0, 3);
      repeat (g) @(negedge clk);
    end
    AXIS_TDATA  = d;
    AXIS_TUSER  = tu;
    AXIS_TVALID = 1'b1;
`ifdef MATRIX_LOADER_TLAST_CHK_EN
    AXIS_TLAST  = last;
`else
    if (last) g = 0;
`endif
    // Outside LOADED this pulse must be ignored.
    compute_finished = ($urandom_range(0, 7) == 0);
    @(negedge clk);
    AXIS_TVALID      = 1'b0;
    compute_finished = 1'b0;
`ifdef MATRIX_LOADER_TLAST_CHK_EN
    AXIS_TLAST       = 1'b0;
`endif
  endtask

  // Sends up to 'limit' beats (limit<0: whole transfer); base<0 means random data.
  task automatic load(input bit new_a, input logic [3:0] kf, input int k, input bit gaps,
                      input int base, input int limit);
    int na, total, nb;
    logic [INW-1:0] d;
    logic [KB:0] tu;
    na    = new_a ? M * k : 0;
    total = na + N * k;
    nb    = (limit >= 0 && limit < total) ? limit : total;
    for (int i = 0; i < nb; i++) begin
      d  = (base >= 0) ? INW'(base + i) : INW'($urandom);
      tu = (i == 0) ? {kf, new_a} : (KB+1)'($urandom);
      if (i == total - 1) chk("loaded_before_last_beat", {31'd0, matrices_loaded}, 32'd0);
      send_beat(d, tu, gaps, i == total - 1);
      if (i < na) begin
        ref_a[i] = d; def_a[i] = 1'b1;
      end else begin
        ref_b[i - na] = d; def_b[i - na] = 1'b1;
      end
    end
  endtask

  task automatic check_mem();
    for (int i = 0; i < 72; i++) begin
      A_read_addr = AAB'(i % 56);
      B_read_addr = BAB'(i);
      @(negedge clk);
      if (i < 56 && def_a[i]) chk($sformatf("A[%0d]", i), {20'd0, A_data}, {20'd0, ref_a[i]});
      if (def_b[i])           chk($sformatf("B[%0d]", i), {20'd0, B_data}, {20'd0, ref_b[i]});
    end
  endtask

  task automatic read_a(input int addr, output logic [INW-1:0] d);
    A_read_addr = AAB'(addr);
    @(negedge clk);
    d = A_data;
  endtask

  task automatic read_b(input int addr, output logic [INW-1:0] d);
    B_read_addr = BAB'(addr);
    @(negedge clk);
    d = B_data;
  endtask

  task automatic check_loaded(input int k, input bit err);
    chk("loaded_after_last_beat", {31'd0, matrices_loaded}, 32'd1);
    chk("tready_when_loaded", {31'd0, AXIS_TREADY}, 32'd0);
    chk("K_after_load", {28'd0, K}, 32'(k));
    chk("err_after_load", {31'd0, load_error}, {31'd0, err});
    check_mem();
    chk("loaded_held", {31'd0, matrices_loaded}, 32'd1);
  endtask

  task automatic release_buffers();
    compute_finished = 1'b1;
    @(negedge clk);
    compute_finished = 1'b0;
    chk("loaded_after_release", {31'd0, matrices_loaded}, 32'd0);
    chk("tready_after_release", {31'd0, AXIS_TREADY}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_tready", {31'd0, AXIS_TREADY}, 32'd0);
    chk("rst_loaded", {31'd0, matrices_loaded}, 32'd0);
    chk("rst_K", {28'd0, K}, 32'd0);
    chk("rst_err", {31'd0, load_error}, 32'd0);
    chk("rst_A_data", {20'd0, A_data}, 32'd0);
    chk("rst_B_data", {20'd0, B_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("tready_after_rst", {31'd0, AXIS_TREADY}, 32'd1);
  endtask

  task automatic reject_beat(input bit new_a, input logic [3:0] kf, input int exp_k);
    send_beat(INW'($urandom), {kf, new_a}, 1'b0, 1'b0);
    chk("reject_tready", {31'd0, AXIS_TREADY}, 32'd1);
    chk("reject_loaded", {31'd0, matrices_loaded}, 32'd0);
    chk("reject_K", {28'd0, K}, 32'(exp_k));
    chk("reject_err", {31'd0, load_error}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [INW-1:0] d;

    vecs[0] = '{new_a: 1'b0, kf: 4'd5,  exp_accept: 1'b0, exp_k: 0, exp_err: 1'b1, gaps: 1'b0};
    vecs[1] = '{new_a: 1'b1, kf: 4'd0,  exp_accept: 1'b0, exp_k: 0, exp_err: 1'b1, gaps: 1'b0};
    vecs[2] = '{new_a: 1'b1, kf: 4'd9,  exp_accept: 1'b0, exp_k: 0, exp_err: 1'b1, gaps: 1'b0};
    vecs[3] = '{new_a: 1'b1, kf: 4'd4,  exp_accept: 1'b1, exp_k: 4, exp_err: 1'b1, gaps: 1'b0};
    vecs[4] = '{new_a: 1'b0, kf: 4'd7,  exp_accept: 1'b1, exp_k: 4, exp_err: 1'b1, gaps: 1'b1};
    vecs[5] = '{new_a: 1'b1, kf: 4'd8,  exp_accept: 1'b1, exp_k: 8, exp_err: 1'b1, gaps: 1'b1};
    vecs[6] = '{new_a: 1'b1, kf: 4'd15, exp_accept: 1'b0, exp_k: 8, exp_err: 1'b1, gaps: 1'b0};
    vecs[7] = '{new_a: 1'b1, kf: 4'd1,  exp_accept: 1'b1, exp_k: 1, exp_err: 1'b1, gaps: 1'b1};
    vecs[8] = '{new_a: 1'b0, kf: 4'd0,  exp_accept: 1'b1, exp_k: 1, exp_err: 1'b1, gaps: 1'b0};
    vecs[9] = '{new_a: 1'b1, kf: 4'd4,  exp_accept: 1'b1, exp_k: 4, exp_err: 1'b1, gaps: 1'b1};

    @(negedge clk);
    do_reset();

    // Full K=4 load with data 1..64, then reuse of A with data 100..135.
    load(1'b1, 4'd4, 4, 1'b0, 1, -1);
    check_loaded(4, 1'b0);
    read_a(0, d);  chk("A0_is_1", {20'd0, d}, 32'd1);
    read_a(27, d); chk("A27_is_28", {20'd0, d}, 32'd28);
    read_b(0, d);  chk("B0_is_29", {20'd0, d}, 32'd29);
    read_b(35, d); chk("B35_is_64", {20'd0, d}, 32'd64);
    release_buffers();

    load(1'b0, 4'd7, 4, 1'b0, 100, -1);
    check_loaded(4, 1'b0);
    read_a(27, d); chk("reuse_A27_is_28", {20'd0, d}, 32'd28);
    read_b(0, d);  chk("reuse_B0_is_100", {20'd0, d}, 32'd100);
    read_b(35, d); chk("reuse_B35_is_135", {20'd0, d}, 32'd135);
    release_buffers();

    // Table of first-beat cases, applied in order from a fresh reset.
    do_reset();
    for (int v = 0; v < 10; v++) begin
      if (!vecs[v].exp_accept) begin
        reject_beat(vecs[v].new_a, vecs[v].kf, vecs[v].exp_k);
        check_mem();
      end else begin
        load(vecs[v].new_a, vecs[v].kf, vecs[v].exp_k, vecs[v].gaps, -1, -1);
        check_loaded(vecs[v].exp_k, vecs[v].exp_err);
        release_buffers();
      end
    end

    // Reset during B beat 20 of a K=4 load: partial data stays, A cannot be reused.
    load(1'b1, 4'd4, 4, 1'b1, -1, 28 + 20);
    reset = 1'b1;
    #1;
    chk("midrst_tready", {31'd0, AXIS_TREADY}, 32'd0);
    chk("midrst_loaded", {31'd0, matrices_loaded}, 32'd0);
    chk("midrst_K", {28'd0, K}, 32'd0);
    chk("midrst_err", {31'd0, load_error}, 32'd0);
    chk("midrst_A_data", {20'd0, A_data}, 32'd0);
    chk("midrst_B_data", {20'd0, B_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_mem();
    reject_beat(1'b0, 4'd4, 0);

`ifdef MATRIX_LOADER_TLAST_CHK_EN
    // TLAST on beat 10 aborts the transfer; the flagged beat is not written.
    do_reset();
    load(1'b1, 4'd4, 4, 1'b0, -1, 9);
    send_beat(INW'($urandom), (KB+1)'($urandom), 1'b0, 1'b1);
    chk("tlast_early_err", {31'd0, load_error}, 32'd1);
    chk("tlast_early_tready", {31'd0, AXIS_TREADY}, 32'd1);
    chk("tlast_early_loaded", {31'd0, matrices_loaded}, 32'd0);
    check_mem();
    reject_beat(1'b0, 4'd4, 4);
    do_reset();
    load(1'b1, 4'd4, 4, 1'b0, -1, -1);
    check_loaded(4, 1'b0);
    release_buffers();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
